// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU function codes,
// pipeline defaults and the operand forward-select encoding.
package alu_issue_stage_pkg;

    // ALU function code width and codes (must match the downstream alu)
    localparam int ALU_FUNCT_WIDTH = 4;

    typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_funct_e;

    // Pipeline defaults
    localparam int REG_ADDR_W_DEFAULT = 5;

    // Forward-select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Priority resolution: MEM beats WB, register 0 is never forwarded
    function automatic logic [1:0] fwd_select(input logic rs_nonzero,
                                              input logic mem_hit,
                                              input logic wb_hit);
        logic [1:0] sel;
        if (rs_nonzero && mem_hit) begin
            sel = FWD_MEM;
        end else if (rs_nonzero && wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Combinational forwarding mux for one source operand: picks the MEM
// result, the WB result or the fallback value by register-index match.
module fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs_addr_i,
    input  logic [N-1:0]  dflt_data_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic [N-1:0]  mem_data_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic [N-1:0]  wb_data_i,
    output logic [N-1:0]  data_o
);

    logic [1:0] sel_s;
    logic       mem_hit_s;
    logic       wb_hit_s;
    logic       rs_nonzero_s;

    // Match detection and priority select of the operand source
    always_comb begin
        rs_nonzero_s = (rs_addr_i != {AW{1'b0}});
        mem_hit_s    = mem_we_i && (mem_rd_i == rs_addr_i);
        wb_hit_s     = wb_we_i && (wb_rd_i == rs_addr_i);
        sel_s        = fwd_select(rs_nonzero_s, mem_hit_s, wb_hit_s);
        case (sel_s)
            FWD_MEM: data_o = mem_data_i;
            FWD_WB:  data_o = wb_data_i;
            default: data_o = dflt_data_i;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the combinational alu. Captures decoded
// operands with MEM/WB forwarding, re-forwards while an entry is stalled,
// supports flush and counts stalled cycles (saturating).
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int N           = 32,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_ADDR_W-1:0]      in_rs1_addr,
    input  logic [REG_ADDR_W-1:0]      in_rs2_addr,
    input  logic [N-1:0]               in_rs1_data,
    input  logic [N-1:0]               in_rs2_data,
    input  logic [N-1:0]               in_imm,
    input  logic                       in_use_imm,
    input  logic [ALU_FUNCT_WIDTH-1:0] in_funct,
    input  logic [REG_ADDR_W-1:0]      in_rd_addr,
    input  logic                       in_rd_we,
    input  logic                       flush,
    input  logic                       mem_fwd_we,
    input  logic [REG_ADDR_W-1:0]      mem_fwd_rd,
    input  logic [N-1:0]               mem_fwd_data,
    input  logic                       wb_fwd_we,
    input  logic [REG_ADDR_W-1:0]      wb_fwd_rd,
    input  logic [N-1:0]               wb_fwd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               alu_x,
    output logic [N-1:0]               alu_y,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic [REG_ADDR_W-1:0]      out_rd_addr,
    output logic                       out_rd_we,
    output logic [STALL_CNT_W-1:0]     stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                       valid_q,   valid_d;
    logic [N-1:0]               x_q,       x_d;
    logic [N-1:0]               y_q,       y_d;
    logic [ALU_FUNCT_WIDTH-1:0] funct_q,   funct_d;
    logic [REG_ADDR_W-1:0]      rd_q,      rd_d;
    logic                       rd_we_q,   rd_we_d;
    logic [REG_ADDR_W-1:0]      rs1_q,     rs1_d;
    logic [REG_ADDR_W-1:0]      rs2_q,     rs2_d;
    logic                       use_imm_q, use_imm_d;
    logic [STALL_CNT_W-1:0]     stall_q,   stall_d;

    logic [N-1:0] cap_x_s;
    logic [N-1:0] cap_y_s;
    logic [N-1:0] ref_x_s;
    logic [N-1:0] ref_y_s;
    logic         capture_s;
    logic         hold_s;

    // Capture-time forwarding of the incoming operands
    fwd_mux #(.N(N), .AW(REG_ADDR_W)) u_cap_rs1 (
        .rs_addr_i(in_rs1_addr), .dflt_data_i(in_rs1_data),
        .mem_we_i(mem_fwd_we), .mem_rd_i(mem_fwd_rd), .mem_data_i(mem_fwd_data),
        .wb_we_i(wb_fwd_we), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
        .data_o(cap_x_s)
    );

    fwd_mux #(.N(N), .AW(REG_ADDR_W)) u_cap_rs2 (
        .rs_addr_i(in_rs2_addr), .dflt_data_i(in_rs2_data),
        .mem_we_i(mem_fwd_we), .mem_rd_i(mem_fwd_rd), .mem_data_i(mem_fwd_data),
        .wb_we_i(wb_fwd_we), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
        .data_o(cap_y_s)
    );

    // Hold-time refresh of the stored operands (fallback keeps held value)
    fwd_mux #(.N(N), .AW(REG_ADDR_W)) u_ref_rs1 (
        .rs_addr_i(rs1_q), .dflt_data_i(x_q),
        .mem_we_i(mem_fwd_we), .mem_rd_i(mem_fwd_rd), .mem_data_i(mem_fwd_data),
        .wb_we_i(wb_fwd_we), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
        .data_o(ref_x_s)
    );

    fwd_mux #(.N(N), .AW(REG_ADDR_W)) u_ref_rs2 (
        .rs_addr_i(rs2_q), .dflt_data_i(y_q),
        .mem_we_i(mem_fwd_we), .mem_rd_i(mem_fwd_rd), .mem_data_i(mem_fwd_data),
        .wb_we_i(wb_fwd_we), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
        .data_o(ref_y_s)
    );

    // Handshake: accept whenever empty or the held entry leaves this cycle
    always_comb begin
        in_ready  = !valid_q || out_ready;
        capture_s = in_valid && in_ready && !flush;
        hold_s    = valid_q && !out_ready && !flush;
    end

    // Next-state for the pipeline entry: flush > capture > hold > drain
    always_comb begin
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        funct_d   = funct_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        if (flush) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else if (capture_s) begin
            valid_d   = 1'b1;
            x_d       = cap_x_s;
            y_d       = in_use_imm ? in_imm : cap_y_s;
            funct_d   = in_funct;
            rd_d      = in_rd_addr;
            rd_we_d   = in_rd_we;
            rs1_d     = in_rs1_addr;
            rs2_d     = in_use_imm ? {REG_ADDR_W{1'b0}} : in_rs2_addr;
            use_imm_d = in_use_imm;
        end else if (hold_s) begin
            x_d = ref_x_s;
            if (!use_imm_q) begin
                y_d = ref_y_s;
            end else begin
                y_d = y_q;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Saturating count of edges on which a valid entry was not consumed
    always_comb begin
        if (valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            x_q       <= {N{1'b0}};
            y_q       <= {N{1'b0}};
            funct_q   <= {ALU_FUNCT_WIDTH{1'b0}};
            rd_q      <= {REG_ADDR_W{1'b0}};
            rd_we_q   <= 1'b0;
            rs1_q     <= {REG_ADDR_W{1'b0}};
            rs2_q     <= {REG_ADDR_W{1'b0}};
            use_imm_q <= 1'b0;
            stall_q   <= {STALL_CNT_W{1'b0}};
        end else begin
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            funct_q   <= funct_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            stall_q   <= stall_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        out_valid    = valid_q;
        alu_x        = x_q;
        alu_y        = y_q;
        alu_funct    = funct_q;
        out_rd_addr  = rd_q;
        out_rd_we    = rd_we_q;
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int SW = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, in_use_imm, in_rd_we, flush;
    logic [AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [N-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic [ALU_FUNCT_WIDTH-1:0] in_funct, alu_funct;
    logic mem_fwd_we, wb_fwd_we;
    logic [AW-1:0] mem_fwd_rd, wb_fwd_rd, out_rd_addr;
    logic [N-1:0]  mem_fwd_data, wb_fwd_data, alu_x, alu_y;
    logic out_valid, out_ready, out_rd_we;
    logic [SW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state (one held instruction)
    bit          m_valid, m_we, m_imm;
    logic [N-1:0] m_x, m_y;
    logic [ALU_FUNCT_WIDTH-1:0] m_funct;
    logic [AW-1:0] m_rd, m_rs1, m_rs2;
    int          m_stall;

    alu_issue_stage #(.N(N), .REG_ADDR_W(AW), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_funct(in_funct),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_funct(alu_funct),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, limit reached");
        $fatal(1, "watchdog");
    end

    // Value an operand takes given the current bypass network
    function automatic logic [N-1:0] m_fwd(input logic [AW-1:0] rs, input logic [N-1:0] dflt);
        if (rs != 5'd0 && mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_data;
        if (rs != 5'd0 && wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
        return dflt;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_imm = 0; m_x = '0; m_y = '0; m_funct = '0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_stall = 0;
    endtask

    // Advance one clock: predict the next model state, then let the edge pass
    task automatic tick();
        bit n_valid, n_we, n_imm, acc;
        logic [N-1:0] n_x, n_y;
        logic [ALU_FUNCT_WIDTH-1:0] n_funct;
        logic [AW-1:0] n_rd, n_rs1, n_rs2;
        int n_stall;
        acc = !m_valid || out_ready;
        n_valid = m_valid; n_we = m_we; n_imm = m_imm; n_x = m_x; n_y = m_y;
        n_funct = m_funct; n_rd = m_rd; n_rs1 = m_rs1; n_rs2 = m_rs2;
        n_stall = (m_valid && !out_ready && m_stall < STALL_MAX) ? m_stall + 1 : m_stall;
        if (flush) begin
            n_valid = 0; n_we = 0;
        end else if (in_valid && acc) begin
            n_valid = 1; n_we = in_rd_we; n_imm = in_use_imm;
            n_x = m_fwd(in_rs1_addr, in_rs1_data);
            n_y = in_use_imm ? in_imm : m_fwd(in_rs2_addr, in_rs2_data);
            n_funct = in_funct; n_rd = in_rd_addr; n_rs1 = in_rs1_addr;
            n_rs2 = in_use_imm ? 5'd0 : in_rs2_addr;
        end else if (m_valid && out_ready) begin
            n_valid = 0;
        end else if (m_valid) begin
            n_x = m_fwd(m_rs1, m_x);
            if (!m_imm) n_y = m_fwd(m_rs2, m_y);
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_we = n_we; m_imm = n_imm; m_x = n_x; m_y = n_y;
        m_funct = n_funct; m_rd = n_rd; m_rs1 = n_rs1; m_rs2 = n_rs2; m_stall = n_stall;
    endtask

    task automatic set_idle();
        in_valid = 0; in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
        in_imm = '0; in_use_imm = 0; in_funct = '0; in_rd_addr = '0; in_rd_we = 0; flush = 0;
        mem_fwd_we = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_we = 0; wb_fwd_rd = '0; wb_fwd_data = '0; out_ready = 1;
    endtask

    task automatic drive_instr(input logic [AW-1:0] rs1, input logic [N-1:0] d1,
                               input logic [AW-1:0] rs2, input logic [N-1:0] d2,
                               input logic use_imm, input logic [N-1:0] imm,
                               input logic [ALU_FUNCT_WIDTH-1:0] fn,
                               input logic [AW-1:0] rd, input logic we);
        in_valid = 1; in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
        in_use_imm = use_imm; in_imm = imm; in_funct = fn; in_rd_addr = rd; in_rd_we = we;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst_n = 0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        in_valid = 1; in_rs1_addr = 5'd3; in_rs1_data = $urandom; in_rs2_data = $urandom;
        in_imm = $urandom; in_rd_we = 1; in_rd_addr = 5'd9; out_ready = 0;
        mem_fwd_we = 1; mem_fwd_rd = 5'd3; mem_fwd_data = $urandom;
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || alu_x !== 32'd0 || alu_y !== 32'd0 || alu_funct !== 4'd0 ||
            out_rd_addr !== 5'd0 || out_rd_we !== 1'b0 || stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b x=%h y=%h f=%h rd=%h we=%b st=%0d required all zero",
                     out_valid, alu_x, alu_y, alu_funct, out_rd_addr, out_rd_we, stall_cycles);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        set_idle();
    endtask

    task automatic test_basic_capture();
        do_reset();
        drive_instr(5'd1, 32'd7, 5'd2, 32'd5, 1'b0, 32'd0, ALU_ADD, 5'd3, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_x !== 32'd7 || alu_y !== 32'd5 || alu_funct !== ALU_ADD ||
            out_rd_addr !== 5'd3 || out_rd_we !== 1'b1) begin
            errors++;
            $display("FAIL basic_capture: got v=%b x=%0d y=%0d f=%0d rd=%0d we=%b required 1,7,5,0,3,1",
                     out_valid, alu_x, alu_y, alu_funct, out_rd_addr, out_rd_we);
        end
        checks++;
        if (alu_x + alu_y !== 32'd12) begin
            errors++; $display("FAIL basic_alu_sum: got %0d required 12", alu_x + alu_y);
        end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || alu_x !== 32'd7) begin
            errors++; $display("FAIL drain: got v=%b x=%0d required v=0 x=7", out_valid, alu_x);
        end
    endtask

    task automatic test_forward_priority();
        do_reset();
        drive_instr(5'd3, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, ALU_SUB, 5'd4, 1'b1);
        mem_fwd_we = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'd100;
        wb_fwd_we = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'd200;
        tick();
        checks++;
        if (alu_x !== 32'd100) begin
            errors++; $display("FAIL fwd_mem_over_wb: got %0d required 100", alu_x);
        end
        mem_fwd_we = 0;
        tick();
        checks++;
        if (alu_x !== 32'd200) begin
            errors++; $display("FAIL fwd_wb_only: got %0d required 200", alu_x);
        end
        drive_instr(5'd0, 32'd33, 5'd0, 32'd44, 1'b0, 32'd0, ALU_ADD, 5'd1, 1'b0);
        mem_fwd_we = 1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        tick();
        checks++;
        if (alu_x !== 32'd33 || alu_y !== 32'd44) begin
            errors++; $display("FAIL fwd_reg_zero: got x=%0d y=%0d required 33 44", alu_x, alu_y);
        end
    endtask

    task automatic test_stall_refresh();
        do_reset();
        drive_instr(5'd6, 32'd9, 5'd4, 32'd1, 1'b0, 32'd0, ALU_OR, 5'd2, 1'b1);
        tick();
        drive_instr(5'd4, 32'd70, 5'd6, 32'd71, 1'b0, 32'd0, ALU_AND, 5'd8, 1'b1);
        out_ready = 0;
        for (int c = 1; c <= 3; c++) begin
            wb_fwd_we = (c == 2); wb_fwd_rd = 5'd4; wb_fwd_data = 32'd55;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready: cycle %0d got %b required 0", c, in_ready);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || alu_y !== 32'd55 || alu_x !== 32'd9 || out_rd_addr !== 5'd2 ||
            stall_cycles !== 4'd3) begin
            errors++;
            $display("FAIL stall_refresh: got v=%b x=%0d y=%0d rd=%0d st=%0d required 1,9,55,2,3",
                     out_valid, alu_x, alu_y, out_rd_addr, stall_cycles);
        end
        in_valid = 0; out_ready = 1; wb_fwd_we = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || alu_y !== 32'd55 || stall_cycles !== 4'd3) begin
            errors++;
            $display("FAIL stall_release: got v=%b y=%0d st=%0d required 0,55,3", out_valid, alu_y, stall_cycles);
        end
    endtask

    task automatic test_immediate();
        do_reset();
        drive_instr(5'd5, 32'd10, 5'd5, 32'd123, 1'b1, 32'hFFFF_FFF8, ALU_ADD, 5'd7, 1'b1);
        mem_fwd_we = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'd77;
        tick();
        checks++;
        if (alu_y !== 32'hFFFF_FFF8 || alu_x !== 32'd77) begin
            errors++; $display("FAIL imm_capture: got x=%h y=%h required 4d fffffff8", alu_x, alu_y);
        end
        in_valid = 0; out_ready = 0; mem_fwd_data = 32'd88;
        tick();
        tick();
        checks++;
        if (alu_y !== 32'hFFFF_FFF8 || alu_x !== 32'd88) begin
            errors++; $display("FAIL imm_hold: got x=%h y=%h required 58 fffffff8", alu_x, alu_y);
        end
        set_idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive_instr(5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, ALU_XOR, 5'd7, 1'b1);
        tick();
        drive_instr(5'd3, 32'd3, 5'd4, 32'd4, 1'b0, 32'd0, ALU_SLT, 5'd9, 1'b1);
        out_ready = 0; flush = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready_held: got %b required 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_rd_we !== 1'b0 || out_rd_addr !== 5'd7 || stall_cycles !== 4'd1) begin
            errors++;
            $display("FAIL flush_held: got v=%b we=%b rd=%0d st=%0d required 0,0,7,1",
                     out_valid, out_rd_we, out_rd_addr, stall_cycles);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_ready_empty: got %b required 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_rd_addr !== 5'd7) begin
            errors++; $display("FAIL flush_drop: got v=%b rd=%0d required 0,7", out_valid, out_rd_addr);
        end
        flush = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rd_addr !== 5'd9 || stall_cycles !== 4'd1) begin
            errors++;
            $display("FAIL flush_resume: got v=%b rd=%0d st=%0d required 1,9,1", out_valid, out_rd_addr, stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive_instr(5'($urandom_range(0, 31)), d, 5'd1, 32'(i), 1'b0, 32'd0, ALU_ADD, 5'(i), 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready: beat %0d got %b required 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || alu_x !== d || alu_y !== 32'(i) || out_rd_addr !== 5'(i)) begin
                errors++;
                $display("FAIL b2b_beat: beat %0d got v=%b x=%h y=%0d rd=%0d required 1,%h,%0d,%0d",
                         i, out_valid, alu_x, alu_y, out_rd_addr, d, i, i);
            end
        end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        drive_instr(5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, ALU_ADD, 5'd1, 1'b1);
        tick();
        in_valid = 0; out_ready = 0;
        repeat (STALL_MAX + 5) tick();
        checks++;
        if (stall_cycles !== 4'hF || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_saturate: got st=%0d v=%b required 15,1", stall_cycles, out_valid);
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_instr(5'd1, 32'd5, 5'd2, 32'd6, 1'b0, 32'd0, ALU_SRA, 5'd3, 1'b1);
        tick();
        in_valid = 0; out_ready = 0;
        tick();
        #2;
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cycles !== 4'd0 || alu_x !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b st=%0d x=%0d required 0,0,0", out_valid, stall_cycles, alu_x);
        end
        @(negedge clk);
        set_idle();
        out_ready = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_in_ready: got %b required 1", in_ready);
        end
        out_ready = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_rs1_addr = 5'($urandom_range(0, 6)); in_rs2_addr = 5'($urandom_range(0, 6));
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_use_imm = ($urandom_range(0, 3) == 0); in_funct = 4'($urandom_range(0, 9));
            in_rd_addr = 5'($urandom_range(0, 31)); in_rd_we = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 9) == 0); out_ready = ($urandom_range(0, 9) < 6);
            mem_fwd_we = 1'($urandom_range(0, 1)); mem_fwd_rd = 5'($urandom_range(0, 6)); mem_fwd_data = $urandom;
            wb_fwd_we = 1'($urandom_range(0, 1)); wb_fwd_rd = 5'($urandom_range(0, 6)); wb_fwd_data = $urandom;
            #1;
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++; $display("FAIL rand_in_ready: cycle %0d got %b required %b", c, in_ready, !m_valid || out_ready);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || alu_x !== m_x || alu_y !== m_y || alu_funct !== m_funct ||
                out_rd_addr !== m_rd || out_rd_we !== m_we || stall_cycles !== SW'(m_stall)) begin
                errors++;
                $display("FAIL rand_state: cycle %0d got v=%b x=%h y=%h f=%h rd=%h we=%b st=%0d required v=%b x=%h y=%h f=%h rd=%h we=%b st=%0d",
                         c, out_valid, alu_x, alu_y, alu_funct, out_rd_addr, out_rd_we, stall_cycles,
                         m_valid, m_x, m_y, m_funct, m_rd, m_we, m_stall);
            end
            if (c % 100 == 99) do_reset();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1;
        model_clear();
        test_reset();
        test_basic_capture();
        test_forward_priority();
        test_stall_refresh();
        test_immediate();
        test_flush();
        test_back_to_back();
        test_stall_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
